pc_redirect_ctrl: RTL and testbench

- Sequencing controller for the fetch-stage PC register. Decides each cycle whether the PC holds, advances by 4, or redirects to a resolved branch/jump target, a trap vector (mtvec/stvec), or an xRET return (mepc/sepc).
- Sits between the IF/EX/MEM stages and the PC register. The PC register only applies pc_next when pc_we=1.

---
 rtl/pc_ctrl_pkg.sv | 20 ++
 rtl/cf_detect.sv | 21 ++
 rtl/pc_redirect_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared opcodes, SYSTEM-instruction encodings and FSM state type for the
// fetch PC sequencing logic.
package pc_ctrl_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_UNIMP = 32'hC000_1073;
    localparam logic [31:0] INST_MRET  = 32'h3020_0073;
    localparam logic [31:0] INST_SRET  = 32'h1020_0073;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_CF  = 2'd1,
        ST_WAIT_MEM = 2'd2
    } pc_state_e;

endpackage

// File: rtl/cf_detect.sv
// Flags a valid fetched instruction that can change control flow
// (jumps, branches, ecall/unimp and xRET encodings).
module cf_detect (
    input  logic [31:0] if_inst,
    input  logic        if_valid,
    output logic        cf_hit
);
    import pc_ctrl_pkg::*;

    logic op_hit;
    logic sys_hit;

    always_comb begin
        op_hit  = (if_inst[6:0] == OPC_JAL) || (if_inst[6:0] == OPC_JALR) ||
                  (if_inst[6:0] == OPC_BRANCH);
        sys_hit = (if_inst == INST_ECALL) || (if_inst == INST_UNIMP) ||
                  (if_inst == INST_MRET)  || (if_inst == INST_SRET);
        cf_hit  = if_valid && (op_hit || sys_hit);
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencing: hold, +4, or redirect to branch/trap/xRET targets.
// Optional PC_MISALIGN_CHECK_EN turns misaligned targets into an M-mode trap.
module pc_redirect_ctrl #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     pc_cur,
    input  logic [31:0]     if_inst,
    input  logic            if_valid,
    input  logic            ex_resolve,
    input  logic            ex_taken,
    input  logic [31:0]     ex_target,
    input  logic            mem_valid,
    input  logic            mmu_data_ready,
    input  logic            trap_req,
    input  logic            trap_to_s,
    input  logic            xret_req,
    input  logic            xret_is_s,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] sepc,
    output logic [31:0]     pc_next,
    output logic            pc_we,
    output logic            if_flush,
    output logic            trap_taken,
    output logic            wait_timeout,
`ifdef PC_MISALIGN_CHECK_EN
    output logic            misalign_trap,
`endif
    output logic [1:0]      state_o
);
    import pc_ctrl_pkg::*;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    pc_state_e   state, state_n, eff_state;
    logic [7:0]  cnt, cnt_n;
    logic        was_wait_cf, was_wait_cf_n;
    logic        cf_hit;
    logic [31:0] pc_plus4;
    logic [31:0] mtvec_pc;
    logic [31:0] redirect_pc;
    logic        mis;

    cf_detect u_cf_detect (
        .if_inst (if_inst),
        .if_valid(if_valid),
        .cf_hit  (cf_hit)
    );

    logic unused_lo;
    assign unused_lo = ^{mtvec[1:0], stvec[1:0]};
    if (XLEN > 32) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^{mtvec[XLEN-1:32], stvec[XLEN-1:32],
                             mepc[XLEN-1:32], sepc[XLEN-1:32]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            cnt         <= '0;
            was_wait_cf <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            was_wait_cf <= was_wait_cf_n;
        end
    end

    always_comb begin
        pc_next       = '0;
        pc_we         = 1'b0;
        if_flush      = 1'b0;
        trap_taken    = 1'b0;
        wait_timeout  = 1'b0;
        mis           = 1'b0;
        cnt_n         = cnt;
        was_wait_cf_n = was_wait_cf;
        redirect_pc   = '0;
        pc_plus4      = pc_cur + 32'd4;
        mtvec_pc      = {mtvec[31:2], 2'b00};
        // Leaving WAIT_MEM behaves exactly like the state it interrupted.
        eff_state     = state;
        if (state == ST_WAIT_MEM)
            eff_state = was_wait_cf ? ST_WAIT_CF : ST_RUN;
        state_n       = eff_state;

        if (trap_req) begin
            pc_we      = 1'b1;
            if_flush   = 1'b1;
            trap_taken = 1'b1;
            pc_next    = trap_to_s ? {stvec[31:2], 2'b00} : mtvec_pc;
            state_n    = ST_RUN;
            cnt_n      = '0;
        end else if (xret_req) begin
            redirect_pc = xret_is_s ? sepc[31:0] : mepc[31:0];
            pc_we       = 1'b1;
            if_flush    = 1'b1;
            pc_next     = redirect_pc;
            state_n     = ST_RUN;
            cnt_n       = '0;
        end else if (mem_valid && !mmu_data_ready) begin
            state_n = ST_WAIT_MEM;
            if (state != ST_WAIT_MEM)
                was_wait_cf_n = (state == ST_WAIT_CF);
        end else if (ex_resolve && ex_taken) begin
            redirect_pc = ex_target;
            pc_we       = 1'b1;
            if_flush    = 1'b1;
            pc_next     = redirect_pc;
            state_n     = ST_RUN;
            cnt_n       = '0;
        end else if (ex_resolve) begin
            pc_we   = 1'b1;
            pc_next = pc_plus4;
            state_n = ST_RUN;
            cnt_n   = '0;
        end else if (eff_state == ST_WAIT_CF) begin
            if (cnt == WAIT_LAST) begin
                pc_we        = 1'b1;
                pc_next      = pc_plus4;
                wait_timeout = 1'b1;
                state_n      = ST_RUN;
                cnt_n        = '0;
            end else begin
                cnt_n = cnt + 8'd1;
            end
        end else if (cf_hit) begin
            state_n = ST_WAIT_CF;
            cnt_n   = '0;
        end else if (if_valid) begin
            pc_we   = 1'b1;
            pc_next = pc_plus4;
        end

`ifdef PC_MISALIGN_CHECK_EN
        if (!trap_req && pc_we && if_flush && redirect_pc[1]) begin
            pc_next    = mtvec_pc;
            trap_taken = 1'b1;
            mis        = 1'b1;
        end
        misalign_trap = mis && !rst;
`endif

        if (rst) begin
            pc_next      = '0;
            pc_we        = 1'b0;
            if_flush     = 1'b0;
            trap_taken   = 1'b0;
            wait_timeout = 1'b0;
            state_n      = ST_RUN;
            cnt_n        = '0;
        end
    end

    assign state_o = rst ? 2'd0 : state;

    logic unused_mis;
    assign unused_mis = mis;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed scenarios plus random traffic
// checked against a rule-level model of the PC sequencing policy.
module tb_pc_redirect_ctrl;

    localparam int WMAX = 15;

    typedef struct {
        bit          rst;
        bit [31:0]   pc_cur;
        bit [31:0]   inst;
        bit          if_valid;
        bit          ex_resolve;
        bit          ex_taken;
        bit [31:0]   ex_target;
        bit          mem_valid;
        bit          mmu_ready;
        bit          trap_req;
        bit          trap_to_s;
        bit          xret_req;
        bit          xret_is_s;
        bit [63:0]   mtvec, stvec, mepc, sepc;
    } stim_t;

    typedef struct {
        string       tag;
        bit [31:0]   pc;
        bit          we;
        bit          flush;
        bit          trap;
        bit          tmo;
        bit          mis;
        bit [1:0]    st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_cur = '0, if_inst = '0, ex_target = '0;
    logic        if_valid = 1'b0, ex_resolve = 1'b0, ex_taken = 1'b0;
    logic        mem_valid = 1'b0, mmu_data_ready = 1'b0;
    logic        trap_req = 1'b0, trap_to_s = 1'b0, xret_req = 1'b0, xret_is_s = 1'b0;
    logic [63:0] mtvec = '0, stvec = '0, mepc = '0, sepc = '0;
    logic [31:0] pc_next;
    logic        pc_we, if_flush, trap_taken, wait_timeout;
    logic [1:0]  state_o;
    logic        mis_o;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.XLEN(64), .WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .if_inst(if_inst), .if_valid(if_valid),
        .ex_resolve(ex_resolve), .ex_taken(ex_taken), .ex_target(ex_target),
        .mem_valid(mem_valid), .mmu_data_ready(mmu_data_ready),
        .trap_req(trap_req), .trap_to_s(trap_to_s), .xret_req(xret_req), .xret_is_s(xret_is_s),
        .mtvec(mtvec), .stvec(stvec), .mepc(mepc), .sepc(sepc),
        .pc_next(pc_next), .pc_we(pc_we), .if_flush(if_flush), .trap_taken(trap_taken),
        .wait_timeout(wait_timeout),
`ifdef PC_MISALIGN_CHECK_EN
        .misalign_trap(mis_o),
`endif
        .state_o(state_o)
    );
`ifndef PC_MISALIGN_CHECK_EN
    assign mis_o = 1'b0;
`endif

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Model: mode 0=running, 1=holding for a control-flow instruction,
    // 2=stalled on memory; held = WAIT_CF cycles spent so far.
    int        m_mode = 0;
    int        m_held = 0;
    bit        m_saved_cf = 0;
    bit [31:0] pc_reg = '0;

    function automatic bit is_cf(input stim_t s);
        bit [6:0] op;
        op = s.inst[6:0];
        if (!s.if_valid) return 0;
        if (op == 7'h6F || op == 7'h67 || op == 7'h63) return 1;
        return (s.inst == 32'h0000_0073 || s.inst == 32'hC000_1073 ||
                s.inst == 32'h3020_0073 || s.inst == 32'h1020_0073);
    endfunction

    task automatic predict(input stim_t s, input string tag, output exp_t e);
        int        eff, nxt;
        bit [31:0] tgt;
        bit        redirect;
        e = '{tag: tag, pc: 32'd0, we: 0, flush: 0, trap: 0, tmo: 0, mis: 0, st: 2'd0};
        if (s.rst) begin
            m_mode = 0; m_held = 0; m_saved_cf = 0;
            return;
        end
        e.st     = 2'(m_mode);
        eff      = (m_mode == 2) ? (m_saved_cf ? 1 : 0) : m_mode;
        nxt      = eff;
        redirect = 0;
        tgt      = 0;
        if (s.trap_req) begin
            e.we = 1; e.flush = 1; e.trap = 1;
            e.pc = (s.trap_to_s ? s.stvec[31:0] : s.mtvec[31:0]) & 32'hFFFF_FFFC;
            nxt = 0; m_held = 0;
        end else if (s.xret_req) begin
            tgt = s.xret_is_s ? s.sepc[31:0] : s.mepc[31:0];
            redirect = 1; nxt = 0;
        end else if (s.mem_valid && !s.mmu_ready) begin
            if (m_mode != 2) m_saved_cf = (m_mode == 1);
            nxt = 2;
        end else if (s.ex_resolve && s.ex_taken) begin
            tgt = s.ex_target; redirect = 1; nxt = 0;
        end else if (s.ex_resolve) begin
            e.we = 1; e.pc = s.pc_cur + 32'd4; nxt = 0;
        end else if (eff == 1) begin
            m_held++;
            if (m_held == WMAX) begin
                e.we = 1; e.tmo = 1; e.pc = s.pc_cur + 32'd4; nxt = 0; m_held = 0;
            end
        end else if (is_cf(s)) begin
            nxt = 1; m_held = 0;
        end else if (s.if_valid) begin
            e.we = 1; e.pc = s.pc_cur + 32'd4;
        end
        if (redirect) begin
            e.we = 1; e.flush = 1; e.pc = tgt;
`ifdef PC_MISALIGN_CHECK_EN
            if (tgt[1]) begin
                e.pc = s.mtvec[31:0] & 32'hFFFF_FFFC; e.trap = 1; e.mis = 1;
            end
`endif
        end
        m_mode = nxt;
    endtask

    function automatic stim_t idle(input bit [31:0] pc);
        stim_t s;
        s = '{rst: 0, pc_cur: pc, inst: 32'h0000_0013, if_valid: 0, ex_resolve: 0,
              ex_taken: 0, ex_target: 0, mem_valid: 0, mmu_ready: 0, trap_req: 0,
              trap_to_s: 0, xret_req: 0, xret_is_s: 0, mtvec: 64'h1000,
              stvec: 64'h2000, mepc: 64'h3000, sepc: 64'h4000};
        return s;
    endfunction

    task automatic apply(input stim_t s, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = s.rst; pc_cur = s.pc_cur; if_inst = s.inst; if_valid = s.if_valid;
        ex_resolve = s.ex_resolve; ex_taken = s.ex_taken; ex_target = s.ex_target;
        mem_valid = s.mem_valid; mmu_data_ready = s.mmu_ready;
        trap_req = s.trap_req; trap_to_s = s.trap_to_s;
        xret_req = s.xret_req; xret_is_s = s.xret_is_s;
        mtvec = s.mtvec; stvec = s.stvec; mepc = s.mepc; sepc = s.sepc;
        predict(s, tag, e);
        if (e.we) pc_reg = e.pc;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (pc_next !== e.pc || pc_we !== e.we || if_flush !== e.flush ||
                    trap_taken !== e.trap || wait_timeout !== e.tmo ||
                    mis_o !== e.mis || state_o !== e.st) begin
                    fails++;
                    $display("FAIL %s: got pc_next=%h we=%b flush=%b trap=%b tmo=%b mis=%b st=%0d, want pc_next=%h we=%b flush=%b trap=%b tmo=%b mis=%b st=%0d",
                             e.tag, pc_next, pc_we, if_flush, trap_taken, wait_timeout, mis_o, state_o,
                             e.pc, e.we, e.flush, e.trap, e.tmo, e.mis, e.st);
                end
            end
        end
    end

    initial begin
        stim_t   s;
        bit [31:0] sys_tab [4];
        sys_tab[0] = 32'h0000_0073; sys_tab[1] = 32'hC000_1073;
        sys_tab[2] = 32'h3020_0073; sys_tab[3] = 32'h1020_0073;

        s = idle(0); s.rst = 1;
        apply(s, "reset0"); apply(s, "reset1");

        s = idle(32'h100); s.if_valid = 1;
        apply(s, "seq_fetch");

        s = idle(32'h200); s.if_valid = 1; s.inst = 32'h0000_0063;
        apply(s, "beq_hold");
        s = idle(32'h200); apply(s, "beq_wait1"); apply(s, "beq_wait2");
        s.ex_resolve = 1; s.ex_taken = 1; s.ex_target = 32'h180;
        apply(s, "beq_taken");
        s = idle(32'h180); apply(s, "after_taken");

        s = idle(32'h300); s.if_valid = 1; s.inst = 32'h0000_006F;
        apply(s, "jal_hold");
        s = idle(32'h300); apply(s, "jal_wait");
        s.mem_valid = 1;
        for (int i = 0; i < 3; i++) apply(s, "mem_stall");
        s.mmu_ready = 1; apply(s, "mem_ready");
        s = idle(32'h300); apply(s, "wait_resume");
        s.ex_resolve = 1; apply(s, "not_taken");

        s = idle(32'h400); s.if_valid = 1; s.inst = 32'h0000_0073;
        s.trap_req = 1; s.mtvec = 64'h8000_0101;
        apply(s, "trap_m");
        s.trap_to_s = 1; s.stvec = 64'h4000;
        apply(s, "trap_s");

        s = idle(32'h500); s.trap_req = 1; s.xret_req = 1; s.ex_resolve = 1;
        s.ex_taken = 1; s.ex_target = 32'h999C; s.mtvec = 64'hFFFF_FFFF_1234_567B;
        apply(s, "collision");
        s = idle(32'h500); s.xret_req = 1; s.xret_is_s = 1; s.sepc = 64'hDEAD_0000_CAFE_F00C;
        apply(s, "sret");

        s = idle(32'h600); s.if_valid = 1; s.inst = 32'h0000_8067;
        apply(s, "jalr_hold");
        s = idle(32'h600);
        for (int i = 0; i < WMAX + 1; i++) apply(s, "timeout_run");

        s = idle(32'h700); s.if_valid = 1; s.inst = 32'h0000_00E7;
        apply(s, "jalr_hold2");
        s = idle(32'h700);
        for (int i = 0; i < 5; i++) apply(s, "wait_pre_rst");
        s.rst = 1; apply(s, "rst_mid_wait");
        s.rst = 0; s.if_valid = 1; apply(s, "after_rst");

        s = idle(32'h800); s.if_valid = 1; s.inst = 32'h0000_0063;
        apply(s, "hold3");
        s = idle(32'h800); s.mem_valid = 1;
        apply(s, "stall3"); s.rst = 1; apply(s, "rst_mid_mem");

        pc_reg = 32'hFFFF_FFFC;
        for (int n = 0; n < 3000; n++) begin
            s = idle(pc_reg);
            s.rst = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 6))
                0: s.inst = {$urandom_range(0, 32'h1FF_FFFF), 7'h6F};
                1: s.inst = {$urandom_range(0, 32'h1FF_FFFF), 7'h67};
                2: s.inst = {$urandom_range(0, 32'h1FF_FFFF), 7'h63};
                3: s.inst = sys_tab[$urandom_range(0, 3)];
                default: s.inst = $urandom();
            endcase
            s.if_valid   = ($urandom_range(0, 3) != 0);
            s.ex_resolve = ($urandom_range(0, 9) < 1);
            s.ex_taken   = $urandom_range(0, 1);
            s.ex_target  = $urandom();
            s.mem_valid  = ($urandom_range(0, 9) < 3);
            s.mmu_ready  = $urandom_range(0, 1);
            s.trap_req   = ($urandom_range(0, 39) == 0);
            s.trap_to_s  = $urandom_range(0, 1);
            s.xret_req   = ($urandom_range(0, 39) == 0);
            s.xret_is_s  = $urandom_range(0, 1);
            s.mtvec = {$urandom(), $urandom()}; s.stvec = {$urandom(), $urandom()};
            s.mepc  = {$urandom(), $urandom()}; s.sepc  = {$urandom(), $urandom()};
            apply(s, "random");
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
